// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default thresholds for the v4 threshold FIFO.
package fifo_pkg;

    localparam int FIFO_AE_DEFAULT = 1;

    function automatic int fifo_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int fifo_af_default(input int depth);
        return depth - 1;
    endfunction

    // Occupancy needs one bit more than the pointers so DEPTH itself is representable.
    function automatic int fifo_usage_w(input int depth);
        return fifo_addr_w(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_v4_ptr.sv
// Pointer that counts 0..DEPTH-1 and wraps, so non-power-of-two depths index correctly.
module fifo_v4_ptr
    import fifo_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = fifo_addr_w(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [AW-1:0] ptr_o
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_o <= '0;
        end else if (clr_i) begin
            ptr_o <= '0;
        end else if (en_i) begin
            ptr_o <= (ptr_o == LAST) ? '0 : ptr_o + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_v4_thresh.sv
// Synchronous FIFO with full-width occupancy, programmable almost flags and sticky error flags.
module fifo_v4_thresh
    import fifo_pkg::*;
#(
    parameter  bit FALL_THROUGH = 1'b0,
    parameter  int DATA_WIDTH   = 32,
    parameter  int DEPTH        = 8,
    parameter  int AF_THRESH    = fifo_af_default(DEPTH),
    parameter  int AE_THRESH    = FIFO_AE_DEFAULT,
    localparam int ADDR_DEPTH   = fifo_addr_w(DEPTH)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic                            testmode_i,
    input  logic [DATA_WIDTH-1:0]           data_i,
    input  logic                            push_i,
    output logic                            full_o,
    input  logic                            pop_i,
    output logic [DATA_WIDTH-1:0]           data_o,
    output logic                            empty_o,
    output logic [fifo_usage_w(DEPTH)-1:0]  usage_o,
    output logic                            almost_full_o,
    output logic                            almost_empty_o,
    output logic                            overflow_o,
    output logic                            underflow_o
);

    if (DATA_WIDTH < 1) begin : g_chk_dw
        $error("fifo_v4_thresh: DATA_WIDTH must be >= 1");
    end
    if (AF_THRESH > DEPTH) begin : g_chk_af
        $error("fifo_v4_thresh: AF_THRESH must be <= DEPTH");
    end
    if (DEPTH > 0 && AE_THRESH >= DEPTH) begin : g_chk_ae
        $error("fifo_v4_thresh: AE_THRESH must be < DEPTH");
    end

    // Error flags are raised on the attempt, not the acceptance, and cleared only by flush/reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (flush_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (push_i && full_o) overflow_o  <= 1'b1;
            if (pop_i && empty_o) underflow_o <= 1'b1;
        end
    end

    if (DEPTH == 0) begin : g_pass
        assign empty_o        = ~push_i;
        assign full_o         = ~pop_i;
        assign data_o         = data_i;
        assign usage_o        = '0;
        assign almost_empty_o = 1'b1;
        assign almost_full_o  = (AF_THRESH == 0);
    end else begin : g_fifo
        localparam logic [ADDR_DEPTH:0] DEPTH_C = (ADDR_DEPTH + 1)'(DEPTH);

        logic [ADDR_DEPTH-1:0] wr_ptr;
        logic [ADDR_DEPTH-1:0] rd_ptr;
        logic [ADDR_DEPTH:0]   count_q;
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [DATA_WIDTH-1:0] mem_n;
        logic                  cnt_zero;
        logic                  ft_bypass;
        logic                  push_acc;
        logic                  pop_acc;
        logic                  mem_en;

        assign cnt_zero = (count_q == '0);
        // Fall-through push+pop on an empty FIFO hands data straight across without touching state.
        assign ft_bypass = FALL_THROUGH && cnt_zero && push_i && pop_i;

        assign full_o         = (count_q == DEPTH_C);
        assign empty_o        = cnt_zero & ~(FALL_THROUGH & push_i);
        assign usage_o        = count_q;
        assign almost_full_o  = (int'(count_q) >= AF_THRESH);
        assign almost_empty_o = (int'(count_q) <= AE_THRESH);
        assign data_o         = (FALL_THROUGH && cnt_zero && push_i) ? data_i : mem_q[rd_ptr];

        assign push_acc = push_i & ~full_o  & ~ft_bypass & ~flush_i;
        assign pop_acc  = pop_i  & ~empty_o & ~ft_bypass & ~flush_i;
        assign mem_en   = push_acc | testmode_i;
        assign mem_n    = push_acc ? data_i : mem_q[wr_ptr];

        fifo_v4_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (flush_i),
            .en_i  (push_acc),
            .ptr_o (wr_ptr)
        );

        fifo_v4_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (flush_i),
            .en_i  (pop_acc),
            .ptr_o (rd_ptr)
        );

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                count_q <= '0;
            end else if (flush_i) begin
                count_q <= '0;
            end else if (push_acc && !pop_acc) begin
                count_q <= count_q + 1'b1;
            end else if (pop_acc && !push_acc) begin
                count_q <= count_q - 1'b1;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            end else if (mem_en) begin
                mem_q[wr_ptr] <= mem_n;
            end
        end
    end

endmodule
